// File: rtl/bb_txn_ctrl_pkg.sv
// Shared types and constants for the bus-bridge transaction sequencer.
package bb_txn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } txn_state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bb_txn_ctrl_req_fifo.sv
// Synchronous request FIFO (module bb_req_fifo) with registered occupancy count.
module bb_req_fifo
    import bb_txn_ctrl_pkg::*;
#(
    parameter  int WIDTH = 21,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bb_txn_ctrl.sv
// Bus-bridge transaction sequencer: queues bridge requests, remaps addresses, runs the master handshake.
// Build macro BB_TXN_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYCLES cycles.
module bb_txn_ctrl
    import bb_txn_ctrl_pkg::*;
#(
    parameter int BB_ADDR_WIDTH      = 12,
    parameter int BUS_ADDR_WIDTH     = 16,
    parameter int BUS_MEM_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 4,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bb_valid,
    output logic                      bb_ready,
    input  logic [BB_ADDR_WIDTH-1:0]  bb_addr,
    input  logic [DATA_WIDTH-1:0]     bb_wdata,
    input  logic                      bb_mode,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      m_req,
    input  logic                      m_grant,
    output logic                      m_start,
    output logic [BUS_ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic                      m_mode,
    input  logic                      m_done,
    input  logic [DATA_WIDTH-1:0]     m_rdata
);

    localparam int ENTRY_W = BB_ADDR_WIDTH + DATA_WIDTH + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    txn_state_e                state_q, state_d;
    logic [BUS_ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0]     m_wdata_q, m_wdata_d;
    logic                      m_mode_q, m_mode_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]          fifo_count;
    logic [ENTRY_W-1:0]        fifo_wdata, fifo_rdata;
    logic [BB_ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]     head_wdata;
    logic                      head_mode;
    logic                      unused_count;

    // Bank select lands just above the slave-local offset; everything higher stays zero.
    function automatic logic [BUS_ADDR_WIDTH-1:0] bus_addr_map(input logic [BB_ADDR_WIDTH-1:0] a);
        logic [BUS_ADDR_WIDTH-1:0] r;
        r                     = '0;
        r[BB_ADDR_WIDTH-2:0]  = a[BB_ADDR_WIDTH-2:0];
        r[BUS_MEM_ADDR_WIDTH] = a[BB_ADDR_WIDTH-1];
        return r;
    endfunction

    assign fifo_push    = bb_valid && !fifo_full;
    assign fifo_wdata   = {bb_addr, bb_wdata, bb_mode};
    assign {head_addr, head_wdata, head_mode} = fifo_rdata;
    assign unused_count = ^fifo_count;

    bb_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef BB_TXN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_expired;
    logic            rsp_err_q, rsp_err_d;

    assign to_cnt_d   = (state_q == ST_WAIT) ? to_cnt_q + TO_W'(1) : '0;
    assign to_expired = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err    = rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign rsp_err        = 1'b0;
`endif

    assign bb_ready  = !fifo_full;
    assign m_req     = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign m_start   = (state_q == ST_REQ) && m_grant;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_mode    = m_mode_q;

    always_comb begin
        state_d     = state_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_mode_d    = m_mode_q;
        rsp_rdata_d = rsp_rdata_q;
        fifo_pop    = 1'b0;
`ifdef BB_TXN_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    m_addr_d  = bus_addr_map(head_addr);
                    m_wdata_d = head_wdata;
                    m_mode_d  = head_mode;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_grant) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the expiry cycle takes priority over the abort.
                if (m_done) begin
                    rsp_rdata_d = (m_mode_q == MODE_WRITE) ? '0 : m_rdata;
                    state_d     = ST_RESP;
`ifdef BB_TXN_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (to_expired) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            m_mode_q    <= MODE_READ;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_mode_q    <= m_mode_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef BB_TXN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_bb_txn_ctrl.sv
// Scoreboard bench for bb_txn_ctrl with arbiter and bus-slave models.
module tb_bb_txn_ctrl;

    localparam int TO_CYC = 8;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        mode;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bb_valid, bb_ready, bb_mode;
    logic [11:0] bb_addr;
    logic [7:0]  bb_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        m_req, m_grant, m_start, m_mode, m_done;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rst_gen = 0;
    int   rsp_seen = 0;
    int   start_cyc = 0;
    int   last_start = -1;
    int   min_gap = 1000;
    int   grant_delay = 0;
    int   done_delay = 1;
    logic grant_en = 1'b1;
    logic no_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bb_txn_ctrl #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bb_valid  (bb_valid),
        .bb_ready  (bb_ready),
        .bb_addr   (bb_addr),
        .bb_wdata  (bb_wdata),
        .bb_mode   (bb_mode),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_mode    (m_mode),
        .m_done    (m_done),
        .m_rdata   (m_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] addr_model(input logic [11:0] a);
        return {3'b000, a[11], 1'b0, a[10:0]};
    endfunction

    task automatic enq(input logic [11:0] a, input logic [7:0] d, input logic md, input logic exp_err);
        int   n = 0;
        rsp_t r;
        bus_t b;
        @(negedge clk);
        while (!bb_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bb_ready) begin
            check_eq("enq_ready_timeout", bb_ready, 1);
            return;
        end
        bb_valid = 1'b1;
        bb_addr  = a;
        bb_wdata = d;
        bb_mode  = md;
        b.addr   = addr_model(a);
        b.wdata  = d;
        b.mode   = md;
        r.err    = exp_err;
        r.rdata  = (exp_err || md) ? 8'h00 : (b.addr[7:0] ^ 8'h99);
        bus_q.push_back(b);
        rsp_q.push_back(r);
        @(posedge clk);
        #1 bb_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", rsp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Arbiter: grants grant_delay cycles after m_req rises.
    initial begin : arb
        int cnt;
        cnt = 0;
        m_grant = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (m_req) cnt++;
            else cnt = 0;
            m_grant = grant_en && m_req && (cnt > grant_delay);
        end
    end

    // Bus slave: checks each start against the expected transaction, answers after done_delay.
    initial begin : slv
        bus_t        b;
        logic        have_b;
        logic [15:0] a;
        int          g;
        int          gap;
        m_done  = 1'b0;
        m_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            if (!rst && m_start) begin
                a = m_addr;
                g = rst_gen;
                if (last_start >= 0) begin
                    gap = cyc - last_start;
                    if (gap < min_gap) min_gap = gap;
                    check_eq("start_gap_ge4", (gap >= 4), 1);
                end
                last_start = cyc;
                start_cyc  = cyc;
                have_b     = (bus_q.size() != 0);
                if (!have_b) check_eq("start_unexp", m_start, 0);
                else begin
                    b = bus_q.pop_front();
                    check_eq("start_addr", m_addr, b.addr);
                    check_eq("start_wdata", m_wdata, b.wdata);
                    check_eq("start_mode", m_mode, b.mode);
                end
                if (!no_done) begin
                    repeat (done_delay) @(negedge clk);
                    if (g == rst_gen && have_b) begin
                        check_eq("hold_addr", m_addr, b.addr);
                        check_eq("hold_wdata", m_wdata, b.wdata);
                        check_eq("hold_mode", m_mode, b.mode);
                    end
                    m_done  = 1'b1;
                    m_rdata = a[7:0] ^ 8'h99;
                    @(negedge clk);
                    m_done  = 1'b0;
                    m_rdata = 8'hEE;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every completion.
    initial begin : mon
        rsp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                rsp_seen++;
                check_eq("rsp_mreq", m_req, 0);
                if (rsp_q.size() == 0) check_eq("rsp_unexp", rsp_valid, 0);
                else begin
                    e   = rsp_q.pop_front();
                    lat = cyc - start_cyc;
                    check_eq("rsp_rdata", rsp_rdata, e.rdata);
                    check_eq("rsp_err", rsp_err, e.err);
                    check_eq("rsp_lat", lat, e.err ? TO_CYC + 1 : done_delay + 1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [11:0] tbl_addr [5];
        logic [7:0]  tbl_data [5];
        logic        tbl_mode [5];
        int          n;
        int          base;
        tbl_addr = '{12'hFFF, 12'h800, 12'h7FF, 12'h001, 12'hABC};
        tbl_data = '{8'h00, 8'h11, 8'h00, 8'hFF, 8'h00};
        tbl_mode = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bb_valid = 1'b0;
        bb_addr  = '0;
        bb_wdata = '0;
        bb_mode  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bb_ready", bb_ready, 1);
        check_eq("rst_m_req", m_req, 0);
        check_eq("rst_m_start", m_start, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_rsp_rdata", rsp_rdata, 0);
        check_eq("rst_m_addr", m_addr, 0);
        check_eq("rst_m_wdata", m_wdata, 0);
        check_eq("rst_m_mode", m_mode, 0);
        @(negedge clk);
        rst = 1'b0;

        grant_delay = 3;
        done_delay  = 2;
        enq(12'h8A5, 8'h00, 1'b0, 1'b0);
        drain();

        grant_delay = 0;
        done_delay  = 3;
        enq(12'h123, 8'h5A, 1'b1, 1'b0);
        drain();

        grant_en = 1'b0;
        min_gap  = 1000;
        for (int i = 0; i < 5; i++) enq(tbl_addr[i], tbl_data[i], tbl_mode[i], 1'b0);
        check_eq("full_ready", bb_ready, 0);
        repeat (3) @(negedge clk);
        check_eq("full_hold", bb_ready, 0);
        grant_delay = 0;
        done_delay  = 1;
        base        = rsp_seen;
        grant_en    = 1'b1;
        n           = 0;
        while (!bb_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_after_pop", rsp_seen - base, 1);
        drain();
        check_eq("start_gap_min", min_gap, 4);

        for (int r = 0; r < 3; r++) begin
            grant_delay = $urandom_range(0, 4);
            done_delay  = $urandom_range(1, 5);
            for (int k = 0; k < 3; k++)
                enq(12'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            drain();
        end

        grant_delay = 0;
        done_delay  = 6;
        enq(12'h456, 8'h00, 1'b0, 1'b0);
        enq(12'h9AB, 8'h77, 1'b1, 1'b0);
        n = 0;
        while (bus_q.size() != 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_test_started", bus_q.size(), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rst_gen++;
        rsp_q.delete();
        bus_q.delete();
        @(posedge clk);
        #1;
        check_eq("midrst_m_req", m_req, 0);
        check_eq("midrst_bb_ready", bb_ready, 1);
        check_eq("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("postrst_m_req", m_req, 0);
        check_eq("postrst_bb_ready", bb_ready, 1);

`ifdef BB_TXN_TIMEOUT_EN
        grant_delay = 1;
        no_done     = 1'b1;
        enq(12'h321, 8'h00, 1'b0, 1'b1);
        drain();
        no_done    = 1'b0;
        done_delay = TO_CYC;
        enq(12'h8A5, 8'h00, 1'b0, 1'b0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
